key_debounce: RTL

- Debounces one mechanical push-button input.
- Produces a clean level plus single-cycle press/release pulses for the LED control logic downstream.
- Sits between the board key pin and key_led's LED control.
- One instance per key (key_in0, key_in1).

---
 rtl/key_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 36 +++
 rtl/key_debounce.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared types and constants for the key debouncer: FSM
//                state encoding, 50 MHz default timing windows and the
//                key-level normalisation helper.
//  Revision    : 1.0  initial release
// ============================================================================
package key_pkg;

    // Debouncer FSM states, fixed two-bit encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // released and stable
        FILT_DN = 2'd1,   // press seen, waiting for it to stay stable
        DOWN    = 2'd2,   // pressed and stable
        FILT_UP = 2'd3    // release seen, waiting for it to stay stable
    } key_fsm_e;

    // Default windows for a 50 MHz clock
    localparam int unsigned KEY_CNT_MAX_DEF  = 1_000_000;   // 20 ms
    localparam int unsigned KEY_LONG_MAX_DEF = 50_000_000;  // 1 s

    // Map a raw key level to the internal convention: 0 = pressed.
    // A level equal to the idle level is "released" (1).
    function automatic logic key_norm(input logic raw, input logic idle_lvl);
        return ~(raw ^ idle_lvl);
    endfunction

endpackage : key_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic two-flop synchronizer for asynchronous inputs, with
//                a configurable reset value so the output comes out of reset
//                at the input's idle level.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int unsigned           WIDTH   = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops; the first may go metastable, the second resolves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Debounces one mechanical push-button. Produces a clean
//                level (1 = released) plus single-cycle press and release
//                pulses. One instance per key.
//                Optional build macro KEY_LONG_PRESS_EN adds a long-press
//                counter and the key_long pulse output.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX  = KEY_CNT_MAX_DEF,
    parameter logic        KEY_IDLE = 1'b1,
    parameter int unsigned LONG_MAX = KEY_LONG_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_flag,
    output logic key_release
`ifdef KEY_LONG_PRESS_EN
    ,
    output logic key_long
`endif
);

    // Filter counter sized to hold CNT_MAX-1, its terminal value
    localparam int unsigned CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    // Both windows must be at least two cycles for the terminal-count logic
    if (CNT_MAX < 2 || LONG_MAX < 2) begin : g_bad_params
        $error("key_debounce: CNT_MAX and LONG_MAX must be >= 2");
    end

    // ------------------------------------------------------------------
    // Input synchronization and normalisation (0 = pressed)
    // ------------------------------------------------------------------
    logic key_meta_sync;
    logic key_sync;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (KEY_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (key_in),
        .dout  (key_meta_sync)
    );

    assign key_sync = key_norm(key_meta_sync, KEY_IDLE);

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    key_fsm_e      state_q,       state_d;
    logic [CW-1:0] cnt_q,         cnt_d;
    logic          key_state_q,   key_state_d;
    logic          key_flag_q,    key_flag_d;
    logic          key_release_q, key_release_d;

    // Next-state logic: counter runs only inside a filter window and is
    // cleared on every state change, so a bounce restarts the window
    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        key_state_d   = key_state_q;
        key_flag_d    = 1'b0;
        key_release_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!key_sync) begin
                    state_d = FILT_DN;
                end
            end

            FILT_DN: begin
                if (key_sync) begin
                    // Bounced back before the window closed: no pulse
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DOWN;
                    key_flag_d  = 1'b1;
                    key_state_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DOWN: begin
                if (key_sync) begin
                    state_d = FILT_UP;
                end
            end

            FILT_UP: begin
                if (!key_sync) begin
                    state_d = DOWN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    key_release_d = 1'b1;
                    key_state_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and registered outputs; reset forces the released idle view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            key_state_q   <= 1'b1;
            key_flag_q    <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_state_q   <= key_state_d;
            key_flag_q    <= key_flag_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_state   = key_state_q;
    assign key_flag    = key_flag_q;
    assign key_release = key_release_q;

`ifdef KEY_LONG_PRESS_EN
    // ------------------------------------------------------------------
    // Long-press detection: counts while the key stays in DOWN
    // ------------------------------------------------------------------
    localparam int unsigned LW = (LONG_MAX > 2) ? $clog2(LONG_MAX) : 1;
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);

    logic [LW-1:0] lcnt_q,      lcnt_d;
    logic          long_done_q, long_done_d;
    logic          key_long_q,  key_long_d;

    // Count only across cycles spent entirely in DOWN; the counter
    // saturates at its terminal value and the done flag limits the pulse
    // to once per stay in DOWN. Entering DOWN (also from a FILT_UP bounce)
    // starts again from zero.
    always_comb begin
        lcnt_d      = '0;
        long_done_d = 1'b0;
        key_long_d  = 1'b0;

        if (state_q == DOWN && state_d == DOWN) begin
            lcnt_d      = lcnt_q;
            long_done_d = long_done_q;
            if (lcnt_q == LONG_LAST) begin
                if (!long_done_q) begin
                    key_long_d  = 1'b1;
                    long_done_d = 1'b1;
                end
            end else begin
                lcnt_d = lcnt_q + 1'b1;
            end
        end
    end

    // Long-press counter and registered pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt_q      <= '0;
            long_done_q <= 1'b0;
            key_long_q  <= 1'b0;
        end else begin
            lcnt_q      <= lcnt_d;
            long_done_q <= long_done_d;
            key_long_q  <= key_long_d;
        end
    end

    assign key_long = key_long_q;
`endif

endmodule : key_debounce
`default_nettype wire
